// File: rtl/wb_openram_pkg.sv
// Shared types and defaults for the two-master Wishbone / OpenRAM arbiter.
package wb_openram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int          DEF_ADDR_WIDTH = 32'sd8;
    localparam logic [31:0] DEF_BASE_ADDR  = 32'h3000_0000;

endpackage

// File: rtl/wb_openram_rr_arb.sv
// Two-requester round-robin picker; the pointer only moves when both masters contend.
module wb_openram_rr_arb
    import wb_openram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_r;

    // one-hot grant from the request pair and the favoured master
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr_r == M1) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // after a contended grant, favour the master that lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= M0;
        end else if (advance && (req == 2'b11)) begin
            ptr_r <= ~ptr_r;
        end
    end

endmodule

// File: rtl/wb_openram_arbiter.sv
// Shares one single-port OpenRAM macro between two classic Wishbone masters.
// Optional macro WB_OPENRAM_ARB_ADDR_CHECK_EN: out-of-window requests get err_o instead of an access.
module wb_openram_arbiter
    import wb_openram_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_sel_i,
    input  logic [31:0]           m0_adr_i,
    input  logic [31:0]           m0_dat_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic [31:0]           m0_dat_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_sel_i,
    input  logic [31:0]           m1_adr_i,
    input  logic [31:0]           m1_dat_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [31:0]           m1_dat_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [31:0]           sram_din0,
    input  logic [31:0]           sram_dout0
);

    state_t                  state_r, state_n;
    logic                    gnt_r, gnt_n, we_r, we_n;
    logic                    csb_r, csb_n, web_r, web_n;
    logic [3:0]              wmask_r, wmask_n;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_n;
    logic [31:0]             din_r, din_n;
    logic                    ack0_r, ack0_n, ack1_r, ack1_n;
    logic                    err0_r, err0_n, err1_r, err1_n;
    logic [31:0]             dat0_r, dat0_n, dat1_r, dat1_n;

    logic [1:0]              req_s, grant_s;
    logic                    advance_s, pick_s, pick_we_s, cyc_g_s, addr_ok_s;
    logic [3:0]              pick_sel_s;
    logic [31:0]             pick_adr_s, pick_dat_s;
    logic                    unused_s;

    assign req_s     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign advance_s = (state_r == IDLE) && (req_s != 2'b00);

    wb_openram_rr_arb u_rr_arb (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .req     (req_s),
        .advance (advance_s),
        .grant   (grant_s)
    );

    assign pick_s     = grant_s[M1];
    assign pick_we_s  = pick_s ? m1_we_i  : m0_we_i;
    assign pick_sel_s = pick_s ? m1_sel_i : m0_sel_i;
    assign pick_adr_s = pick_s ? m1_adr_i : m0_adr_i;
    assign pick_dat_s = pick_s ? m1_dat_i : m0_dat_i;
    assign cyc_g_s    = (gnt_r == M1) ? m1_cyc_i : m0_cyc_i;

`ifdef WB_OPENRAM_ARB_ADDR_CHECK_EN
    assign addr_ok_s = (pick_adr_s[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign unused_s  = &{1'b0, pick_adr_s[1:0]};
`else
    // upper address bits are don't-care: the window aliases across the bus
    assign addr_ok_s = 1'b1;
    assign unused_s  = &{1'b0, pick_adr_s[1:0], pick_adr_s[31:ADDR_WIDTH+2], BASE_ADDR};
`endif

    // next-state and next-output logic for the access sequencer
    always_comb begin
        state_n = state_r;
        gnt_n   = gnt_r;
        we_n    = we_r;
        csb_n   = 1'b1;
        web_n   = 1'b1;
        wmask_n = wmask_r;
        addr_n  = addr_r;
        din_n   = din_r;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        err0_n  = 1'b0;
        err1_n  = 1'b0;
        dat0_n  = dat0_r;
        dat1_n  = dat1_r;
        case (state_r)
            IDLE: begin
                if (req_s != 2'b00) begin
                    gnt_n = pick_s;
                    we_n  = pick_we_s;
                    if (addr_ok_s) begin
                        csb_n   = 1'b0;
                        web_n   = ~pick_we_s;
                        wmask_n = pick_we_s ? pick_sel_s : 4'b0000;
                        addr_n  = pick_adr_s[ADDR_WIDTH+1:2];
                        din_n   = pick_dat_s;
                        state_n = REQ;
                    end else begin
                        err0_n  = (pick_s == M0);
                        err1_n  = (pick_s == M1);
                        state_n = ACK;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                // the macro has already latched the access; an abort only drops the ack
                if (!cyc_g_s) begin
                    state_n = IDLE;
                end else if (we_r) begin
                    ack0_n  = (gnt_r == M0);
                    ack1_n  = (gnt_r == M1);
                    state_n = ACK;
                end else begin
                    state_n = RD;
                end
            end
            RD: begin
                if (!cyc_g_s) begin
                    state_n = IDLE;
                end else begin
                    if (gnt_r == M1) begin
                        dat1_n = sram_dout0;
                    end else begin
                        dat0_n = sram_dout0;
                    end
                    ack0_n  = (gnt_r == M0);
                    ack1_n  = (gnt_r == M1);
                    state_n = ACK;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // state and output registers; csb0 releases asynchronously on reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_r <= IDLE;
            gnt_r   <= M0;
            we_r    <= 1'b0;
            csb_r   <= 1'b1;
            web_r   <= 1'b1;
            wmask_r <= 4'b0000;
            addr_r  <= '0;
            din_r   <= 32'h0000_0000;
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            err0_r  <= 1'b0;
            err1_r  <= 1'b0;
            dat0_r  <= 32'h0000_0000;
            dat1_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_n;
            gnt_r   <= gnt_n;
            we_r    <= we_n;
            csb_r   <= csb_n;
            web_r   <= web_n;
            wmask_r <= wmask_n;
            addr_r  <= addr_n;
            din_r   <= din_n;
            ack0_r  <= ack0_n;
            ack1_r  <= ack1_n;
            err0_r  <= err0_n;
            err1_r  <= err1_n;
            dat0_r  <= dat0_n;
            dat1_r  <= dat1_n;
        end
    end

    assign sram_csb0   = csb_r;
    assign sram_web0   = web_r;
    assign sram_wmask0 = wmask_r;
    assign sram_addr0  = addr_r;
    assign sram_din0   = din_r;
    assign m0_ack_o    = ack0_r;
    assign m1_ack_o    = ack1_r;
    assign m0_err_o    = err0_r;
    assign m1_err_o    = err1_r;
    assign m0_dat_o    = dat0_r;
    assign m1_dat_o    = dat1_r;

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// Self-checking bench for wb_openram_arbiter: vector table, random traffic vs. a transaction model, corner sequences.
module tb_wb_openram_arbiter;

    localparam int AW = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [31:0] sram_din0, sram_dout0;
    logic        mem_clr;
    logic [31:0] sram_mem [256];

    always #5 wb_clk_i = ~wb_clk_i;

    wb_openram_arbiter dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_dat_o(m1_dat_o),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    // OpenRAM-style macro: samples on the rising edge, read data valid the following cycle
    always @(posedge wb_clk_i) begin
        if (mem_clr) begin
            for (int a = 0; a < 256; a++) sram_mem[a] <= 32'h0;
        end else if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else begin
                sram_dout0 <= sram_mem[sram_addr0];
            end
        end
    end

    typedef struct {
        logic        v;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } req_t;

    typedef struct {
        req_t        r0;
        req_t        r1;
        int          exp_first;
        logic        rd0_chk;
        logic [31:0] exp_rd0;
        logic        rd1_chk;
        logic [31:0] exp_rd1;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [256];
    int          mptr;
    logic [31:0] last_dat [2];
    bit          known [2];
    vec_t        vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic v, input logic we, input logic [3:0] sel,
                                input logic [31:0] adr, input logic [31:0] dat);
        req_t r;
        r.v = v; r.we = we; r.sel = sel; r.adr = adr; r.dat = dat;
        return r;
    endfunction

    function automatic vec_t mkv(input req_t r0, input req_t r1, input int f,
                                 input logic c0, input logic [31:0] e0,
                                 input logic c1, input logic [31:0] e1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.exp_first = f;
        v.rd0_chk = c0; v.exp_rd0 = e0; v.rd1_chk = c1; v.exp_rd1 = e1;
        return v;
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    // Transaction-level reference: contended requests resolve by the pointer, then run back to back.
    task automatic model_apply(input req_t r0, input req_t r1, output int first,
                               output logic [31:0] rd0, output logic [31:0] rd1);
        req_t rr [2];
        int   i, idx;
        rr[0] = r0; rr[1] = r1; rd0 = 32'h0; rd1 = 32'h0;
        if (r0.v && r1.v) begin
            first = mptr;
            mptr  = 1 - mptr;
        end else begin
            first = r0.v ? 0 : 1;
        end
        for (int k = 0; k < 2; k++) begin
            i = (k == 0) ? first : 1 - first;
            if (rr[i].v) begin
                idx = int'(rr[i].adr[AW+1:2]);
                if (rr[i].we) begin
                    ref_mem[idx] = (ref_mem[idx] & ~bmask(rr[i].sel)) | (rr[i].dat & bmask(rr[i].sel));
                end else begin
                    last_dat[i] = ref_mem[idx];
                    known[i]    = 1'b1;
                    if (i == 0) rd0 = ref_mem[idx];
                    else        rd1 = ref_mem[idx];
                end
            end
        end
    endtask

    task automatic drive(input int m, input req_t r);
        if (m == 0) begin
            m0_cyc_i = r.v; m0_stb_i = r.v; m0_we_i = r.we;
            m0_sel_i = r.sel; m0_adr_i = r.adr; m0_dat_i = r.dat;
        end else begin
            m1_cyc_i = r.v; m1_stb_i = r.v; m1_we_i = r.we;
            m1_sel_i = r.sel; m1_adr_i = r.adr; m1_dat_i = r.dat;
        end
    endtask

    function automatic bit fields_match(input req_t r);
        return (sram_addr0 == r.adr[AW+1:2]) && (sram_web0 == !r.we) &&
               (sram_wmask0 == (r.we ? r.sel : 4'h0)) && (sram_din0 == r.dat);
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_csb0"},  32'(sram_csb0),   32'h1);
        chk({tag, "_web0"},  32'(sram_web0),   32'h1);
        chk({tag, "_wmask"}, 32'(sram_wmask0), 32'h0);
        chk({tag, "_addr"},  32'(sram_addr0),  32'h0);
        chk({tag, "_din"},   sram_din0,        32'h0);
        chk({tag, "_acks"},  {30'h0, m1_ack_o, m0_ack_o}, 32'h0);
        chk({tag, "_errs"},  {30'h0, m1_err_o, m0_err_o}, 32'h0);
        chk({tag, "_dat0"},  m0_dat_o, 32'h0);
        chk({tag, "_dat1"},  m1_dat_o, 32'h0);
    endtask

    // Issue both requests in the same IDLE cycle; each master holds until its ack.
    task automatic run(input req_t r0, input req_t r1, output int first,
                       output logic [31:0] rd0, output logic [31:0] rd1);
        int n, n_first, csb_cnt, nvalid, lat0, lat1;
        bit done0, done1, ok;
        lat0 = r0.we ? 3 : 4;
        lat1 = r1.we ? 3 : 4;
        done0 = !r0.v; done1 = !r1.v;
        nvalid = int'(r0.v) + int'(r1.v);
        first = -1; n_first = 0; csb_cnt = 0; rd0 = 32'h0; rd1 = 32'h0; n = 0;
        drive(0, r0);
        drive(1, r1);
        while (!(done0 && done1) && n < 12) begin
            @(posedge wb_clk_i); #1;
            n++;
            if (!sram_csb0) begin
                csb_cnt++;
                ok = (!done0 && fields_match(r0)) || (!done1 && fields_match(r1));
                chk("sram_fields", 32'(ok), 32'h1);
            end
            if (m0_err_o || m1_err_o) chk("err_pulse", {30'h0, m1_err_o, m0_err_o}, 32'h0);
            if (m0_ack_o) begin
                chk("m0_ack_expected", 32'(done0), 32'h0);
                if (!done0) begin
                    chk("m0_ack_cycle", n, (first < 0) ? lat0 - 1 : n_first + lat0);
                    if (first < 0) begin first = 0; n_first = n; end
                    rd0 = m0_dat_o; done0 = 1'b1;
                    drive(0, mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
                end
            end
            if (m1_ack_o) begin
                chk("m1_ack_expected", 32'(done1), 32'h0);
                if (!done1) begin
                    chk("m1_ack_cycle", n, (first < 0) ? lat1 - 1 : n_first + lat1);
                    if (first < 0) begin first = 1; n_first = n; end
                    rd1 = m1_dat_o; done1 = 1'b1;
                    drive(1, mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
                end
            end
        end
        chk("ack_timeout", 32'(done0 && done1), 32'h1);
        chk("csb_cycles", csb_cnt, nvalid);
        drive(0, mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
        drive(1, mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
        @(posedge wb_clk_i); #1;
        chk("idle_no_ack", {30'h0, m1_ack_o, m0_ack_o}, 32'h0);
        if (known[0]) chk("m0_dat_hold", m0_dat_o, last_dat[0]);
        if (known[1]) chk("m1_dat_hold", m1_dat_o, last_dat[1]);
    endtask

    function automatic req_t rand_req();
        req_t        r;
        logic [31:0] hi;
        logic [3:0]  idx;
        hi  = $urandom;
`ifdef WB_OPENRAM_ARB_ADDR_CHECK_EN
        hi  = 32'h3000_0000;
`endif
        idx = 4'($urandom_range(0, 15));
        r.v   = 1'b0;
        r.we  = 1'($urandom_range(0, 1));
        r.sel = 4'($urandom);
        r.adr = {hi[31:AW+2], 4'h0, idx, 2'($urandom)};
        r.dat = $urandom;
        return r;
    endfunction

    initial begin
        req_t        none, a, b;
        int          f, mf, ack_seen;
        logic [31:0] d0, d1, md0, md1;
        none = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        mptr = 0; last_dat[0] = 32'h0; last_dat[1] = 32'h0; known[0] = 1'b1; known[1] = 1'b1;

        vecs[0] = mkv(mk(1, 1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF), none, 0, 0, 32'h0, 0, 32'h0);
        vecs[1] = mkv(mk(1, 0, 4'hF, 32'h3000_0010, 32'h0), none, 0, 1, 32'hDEAD_BEEF, 0, 32'h0);
        vecs[2] = mkv(none, mk(1, 1, 4'hF, 32'h3000_0020, 32'h1122_3344), 1, 0, 32'h0, 0, 32'h0);
        vecs[3] = mkv(none, mk(1, 1, 4'b0100, 32'h3000_0020, 32'h00AA_0000), 1, 0, 32'h0, 0, 32'h0);
        vecs[4] = mkv(mk(1, 0, 4'hF, 32'h3000_0020, 32'h0), none, 0, 1, 32'h11AA_3344, 0, 32'h0);
        vecs[5] = mkv(mk(1, 1, 4'hF, 32'h3000_0030, 32'hCAFE_F00D), mk(1, 0, 4'hF, 32'h3000_0010, 32'h0),
                      0, 0, 32'h0, 1, 32'hDEAD_BEEF);
        vecs[6] = mkv(mk(1, 0, 4'hF, 32'h3000_0030, 32'h0), mk(1, 1, 4'b0011, 32'h3000_0034, 32'h1234_5678),
                      1, 1, 32'hCAFE_F00D, 0, 32'h0);
        vecs[7] = mkv(mk(1, 0, 4'hF, 32'h3000_0034, 32'h0), mk(1, 0, 4'hF, 32'h3000_0020, 32'h0),
                      0, 1, 32'h0000_5678, 1, 32'h11AA_3344);
        vecs[8] = mkv(mk(1, 1, 4'h0, 32'h3000_0020, 32'hFFFF_FFFF), mk(1, 0, 4'hF, 32'h3000_0020, 32'h0),
                      1, 0, 32'h0, 1, 32'h11AA_3344);
        vecs[9] = mkv(none, mk(1, 0, 4'hF, 32'h3000_0020, 32'h0), 1, 0, 32'h0, 1, 32'h11AA_3344);

        drive(0, none);
        drive(1, none);
        mem_clr = 1'b1;
        wb_rst_n_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check_reset("reset");
        mem_clr = 1'b0;
        wb_rst_n_i = 1'b1;
        @(posedge wb_clk_i); #1;

        for (int i = 0; i < 10; i++) begin
            model_apply(vecs[i].r0, vecs[i].r1, mf, md0, md1);
            run(vecs[i].r0, vecs[i].r1, f, d0, d1);
            chk($sformatf("vec%0d_first", i), f, vecs[i].exp_first);
            if (vecs[i].rd0_chk) chk($sformatf("vec%0d_rd0", i), d0, vecs[i].exp_rd0);
            if (vecs[i].rd1_chk) chk($sformatf("vec%0d_rd1", i), d1, vecs[i].exp_rd1);
        end

        for (int it = 0; it < 40; it++) begin
            int vm;
            a = rand_req();
            b = rand_req();
            vm = int'($urandom_range(1, 3));
            a.v = vm[0];
            b.v = vm[1];
            model_apply(a, b, mf, md0, md1);
            run(a, b, f, d0, d1);
            chk("rand_first", f, mf);
            if (a.v && !a.we) chk("rand_rd0", d0, md0);
            if (b.v && !b.we) chk("rand_rd1", d1, md1);
        end

        // m1 read abandoned while the data phase is in flight
        ack_seen = 0;
        drive(1, mk(1, 0, 4'hF, 32'h3000_0040, 32'h0));
        @(posedge wb_clk_i); #1;
        if (m1_ack_o) ack_seen++;
        @(posedge wb_clk_i); #1;
        if (m1_ack_o) ack_seen++;
        drive(1, none);
        for (int k = 0; k < 4; k++) begin
            @(posedge wb_clk_i); #1;
            if (m1_ack_o) ack_seen++;
        end
        chk("abort_no_ack", ack_seen, 0);
        known[1] = 1'b0;
        a = mk(1, 0, 4'hF, 32'h3000_0010, 32'h0);
        model_apply(a, none, mf, md0, md1);
        run(a, none, f, d0, d1);
        chk("abort_next_first", f, 0);
        chk("abort_next_rd0", d0, md0);

        // leave the pointer favouring m1 so the reset really has something to undo
        if (mptr == 0) begin
            a = mk(1, 0, 4'hF, 32'h3000_0010, 32'h0);
            b = mk(1, 0, 4'hF, 32'h3000_0020, 32'h0);
            model_apply(a, b, mf, md0, md1);
            run(a, b, f, d0, d1);
            chk("pre_rst_first", f, mf);
        end
        drive(0, mk(1, 1, 4'hF, 32'h3000_0050, 32'h5555_AAAA));
        @(posedge wb_clk_i); #1;
        chk("rst_req_csb_low", 32'(sram_csb0), 32'h0);
        wb_rst_n_i = 1'b0;
        #1;
        check_reset("midreset");
        drive(0, none);
        @(posedge wb_clk_i); #1;
        wb_rst_n_i = 1'b1;
        mptr = 0; last_dat[0] = 32'h0; last_dat[1] = 32'h0; known[0] = 1'b1; known[1] = 1'b1;
        a = mk(1, 0, 4'hF, 32'h3000_0050, 32'h0);
        b = mk(1, 0, 4'hF, 32'h3000_0010, 32'h0);
        model_apply(a, b, mf, md0, md1);
        run(a, b, f, d0, d1);
        chk("rst_first_m0", f, 0);
        chk("rst_write_dropped", d0, md0);
        chk("rst_rd1", d1, md1);

`ifdef WB_OPENRAM_ARB_ADDR_CHECK_EN
        begin
            int err_n, err_cnt, csb_low, acks;
            err_n = 0; err_cnt = 0; csb_low = 0; acks = 0;
            drive(0, mk(1, 0, 4'hF, 32'h3000_0400, 32'h0));
            for (int n = 1; n <= 4; n++) begin
                @(posedge wb_clk_i); #1;
                if (!sram_csb0) csb_low++;
                if (m0_ack_o) acks++;
                if (m0_err_o) begin
                    err_cnt++;
                    if (err_n == 0) err_n = n;
                    drive(0, none);
                end
            end
            drive(0, none);
            chk("oow_err_cycle", err_n, 1);
            chk("oow_err_pulses", err_cnt, 1);
            chk("oow_no_csb", csb_low, 0);
            chk("oow_no_ack", acks, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_openram_arbiter.md
Name: wb_openram_arbiter

Overview:
Two-port Wishbone arbiter that shares one single-port OpenRAM macro (1 KiB, 256 x 32, port 0 read/write) between the management SoC bus (m0) and a user-logic Wishbone master (m1). It arbitrates requests round-robin and sequences the macro's active-low chip-select and write-enable. It captures read data and returns classic, non-pipelined Wishbone acks. It sits in the user project area, between both masters and the OpenRAM macro instance.

Parameters:
ADDR_WIDTH, 8, SRAM word-address width; 2^ADDR_WIDTH 32-bit words.
BASE_ADDR, 32'h3000_0000, byte base address of the RAM window; used only with the optional feature.

Ports:
wb_clk_i  in  1  system clock, all logic on the rising edge
wb_rst_n_i  in  1  asynchronous active-low reset
m0_cyc_i, m1_cyc_i  in  1  Wishbone cycle
m0_stb_i, m1_stb_i  in  1  Wishbone strobe
m0_we_i, m1_we_i  in  1  write enable
m0_sel_i, m1_sel_i  in  4  byte selects
m0_adr_i, m1_adr_i  in  32  byte address; word index = adr[ADDR_WIDTH+1:2]
m0_dat_i, m1_dat_i  in  32  write data
m0_ack_o, m1_ack_o  out  1  acknowledge, one-cycle pulse
m0_err_o, m1_err_o  out  1  error, one-cycle pulse (optional feature only)
m0_dat_o, m1_dat_o  out  32  read data
sram_csb0  out  1  chip select, active low
sram_web0  out  1  write enable, active low
sram_wmask0  out  4  byte write mask
sram_addr0  out  ADDR_WIDTH  word address
sram_din0  out  32  write data
sram_dout0  in  32  read data

Behaviour:
- Interface: one clock (wb_clk_i); reset is asynchronous and active-low (wb_rst_n_i).
- Reset values: state IDLE; sram_csb0=1; sram_web0=1; sram_wmask0=0; sram_addr0=0; sram_din0=0; all ack_o/err_o=0; both dat_o=0; round-robin pointer favours m0.
- All outputs are registered.
- A master requests when cyc_i & stb_i.
- FSM states: IDLE, REQ, RD, ACK.
- IDLE:
  - Nothing requested: stay in IDLE.
  - One master requesting: grant it.
  - Both requesting: grant the master the pointer favours, then point the pointer at the other master.
  - On grant: register the SRAM controls. csb0=0; web0=~we; wmask0=sel when writing, else 0; addr0=adr[ADDR_WIDTH+1:2]; din0=dat_i. Next state REQ.
- REQ: the macro samples its inputs at the closing edge. Drive csb0=1, web0=1. Next state RD for reads, ACK for writes.
- RD: capture sram_dout0 into the granted master's dat_o at the closing edge. Next state ACK.
- ACK: pulse the granted master's ack_o for exactly one cycle, then go to IDLE.
- Latency from the first request cycle in IDLE:
  - read: ack in the 4th cycle (IDLE, REQ, RD, ACK);
  - write: ack in the 3rd cycle.
- Sustained throughput: one access per 4 cycles (reads) or 3 cycles (writes). At most one transaction is outstanding.
- The non-granted master is held off (no ack) until the following IDLE. No requests are queued.
- Both dat_o hold their last value between reads. The non-granted master's dat_o never changes.
- Abort: if the granted master drops cyc_i before ACK, the SRAM access still completes (writes commit), ack is suppressed, and the FSM goes to IDLE.
- Changing adr/dat/sel mid-transaction has no effect; they are latched at grant.
- sel_i=0 on a write: access occurs with wmask0=0 (no bytes change) and is acked normally.
- Reset asserted mid-transaction: everything returns to reset values immediately; csb0 rises asynchronously.

Optional Feature:
Macro WB_OPENRAM_ARB_ADDR_CHECK_EN.
- Defined: at grant, if adr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2], the request takes no SRAM access (csb0 stays 1). The FSM goes straight to ACK, where err_o pulses instead of ack_o. The round-robin pointer still advances.
- Not defined: upper address bits are ignored (the window aliases), and both err_o are tied to 0.

Decomposition:
- Package wb_openram_pkg:
  - FSM state encoding (IDLE, REQ, RD, ACK, 2 bits);
  - master index constants M0=0, M1=1;
  - default ADDR_WIDTH and BASE_ADDR.
- Sub-module wb_openram_rr_arb: 2-requester round-robin picker with registered pointer. Inputs are the request pair and an advance strobe; outputs are the one-hot grant.

Test Plan:
1. Reset, then m0 writes 0xDEADBEEF to 0x3000_0010 with sel=4'hF, then reads it back -> csb0 low for 1 cycle per access at addr0=0x04; write ack on cycle 3, read ack on cycle 4, m0_dat_o=0xDEADBEEF.
2. m0 and m1 request in the same cycle, repeated 4 times -> grants alternate m0,m1,m0,m1; the waiting master receives no ack until its own transaction.
3. Write 0x11223344 to a word, then a byte write of 0xAA with sel=4'b0100 -> wmask0=4'b0100; readback returns 0x11AA3344.
4. m1 read, m1_cyc_i dropped during RD -> no m1_ack_o; FSM back in IDLE; a following m0 request is served with normal latency.
5. Reset pulled low during REQ of a write -> csb0=1 and ack=0 immediately; after release, first grant goes to m0 when both masters request.
6. With WB_OPENRAM_ARB_ADDR_CHECK_EN, m0 reads 0x3000_0400 -> no csb0 assertion, m0_err_o pulse on cycle 2, m0_ack_o=0.
